// File: rtl/r16_ntt_pkg.sv
// Shared definitions for the radix-16 NTT stage scheduler and related
// pipeline controllers: controller states, default geometry, width helper.
package r16_ntt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } r16_state_e;

  // 16384-point transform: 3 radix-16 stages followed by one radix-4 stage
  localparam int R16_NUM_STAGE = 4;
  localparam int R16_GROUPS    = 1024;
  localparam int R16_PIPE_LAT  = 4;

  // Bits needed to hold the values 0..n-1, never less than one bit
  function automatic int r16_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/r16_drain_cnt.sv
// Loadable down-counter with a zero flag, used to wait out a fixed pipeline
// depth. Clear wins over load, load wins over decrement, and the count
// saturates at zero rather than wrapping.
module r16_drain_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count selection
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/r16_ntt_stage_sched.sv
// Stage scheduler for the radix-16 NTT butterfly pipeline. Holds the modulus
// for the whole transform, issues butterfly groups stage by stage, and drains
// the pipeline between stages so a stage never reads data still in flight.
module r16_ntt_stage_sched
  import r16_ntt_pkg::*;
#(
  parameter int P_WIDTH   = 64,
  parameter int NUM_STAGE = R16_NUM_STAGE,
  parameter int GROUPS    = R16_GROUPS,
  parameter int PIPE_LAT  = R16_PIPE_LAT,
  parameter int STG_W     = 2,
  parameter int GRP_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [P_WIDTH-1:0] N_in,
  input  logic               bf_ready,
  output logic               busy,
  output logic [P_WIDTH-1:0] N_out,
  output logic               issue_valid,
  output logic [STG_W-1:0]   stage_idx,
  output logic [GRP_W-1:0]   group_idx,
  output logic               r4_mode,
  output logic               done
);

  localparam int               DRN_W    = r16_width(PIPE_LAT);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGE - 1);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(PIPE_LAT - 1);

  r16_state_e         state_q, state_d;
  logic [P_WIDTH-1:0] n_q, n_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [GRP_W-1:0]   group_q, group_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               r4_q, r4_d;

  logic drn_clr;
  logic drn_load;
  logic drn_dec;
  logic drn_zero;

  // Counts out the pipeline depth between the last issue of a stage and the
  // first issue of the next one
  r16_drain_cnt #(
    .W(DRN_W)
  ) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (drn_clr),
    .load     (drn_load),
    .load_val (DRN_INIT),
    .dec      (drn_dec),
    .zero     (drn_zero)
  );

  // Next-state, counter and output decode; abort overrides every transition
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    stage_d  = stage_q;
    group_d  = group_q;
    drn_clr  = 1'b0;
    drn_load = 1'b0;
    drn_dec  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      stage_d = '0;
      group_d = '0;
      drn_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_d     = N_in;
            stage_d = '0;
            group_d = '0;
            state_d = LOAD;
          end
        end
        // One cycle for the new modulus to reach the pipeline's delay taps
        LOAD: begin
          state_d = ISSUE;
        end
        ISSUE: begin
          if (bf_ready) begin
            if (group_q == LAST_GRP) begin
              group_d  = '0;
              drn_load = 1'b1;
              state_d  = DRAIN;
            end else begin
              group_d = group_q + GRP_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drn_zero) begin
            if (stage_q == LAST_STG) begin
              state_d = DONE;
            end else begin
              stage_d = stage_q + STG_W'(1);
              state_d = ISSUE;
            end
          end else begin
            drn_dec = 1'b1;
          end
        end
        DONE: begin
          stage_d = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          stage_d = '0;
          group_d = '0;
          drn_clr = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    r4_d   = busy_d && (stage_d == LAST_STG);
  end

  // Controller state, held modulus, issue counters and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      stage_q <= '0;
      group_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r4_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      stage_q <= stage_d;
      group_q <= group_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r4_q    <= r4_d;
    end
  end

  assign busy        = busy_q;
  assign N_out       = n_q;
  assign stage_idx   = stage_q;
  assign group_idx   = group_q;
  assign r4_mode     = r4_q;
  assign done        = done_q;
  // Issue follows the pipeline handshake in the same cycle
  assign issue_valid = (state_q == ISSUE) && bf_ready;

endmodule

// File: tb/tb_r16_ntt_stage_sched.sv
// Self-checking bench for r16_ntt_stage_sched: a reduced-geometry instance
// driven from a vector table and random handshake patterns against a
// cycle-schedule model, plus a default-geometry instance for full length.
module tb_r16_ntt_stage_sched;

  localparam int NS   = 2;
  localparam int GR   = 4;
  localparam int PL   = 3;
  localparam int MAXC = 96;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, bf_ready;
  logic [63:0] N_in;
  logic        busy, issue_valid, r4_mode, done;
  logic [63:0] N_out;
  logic [0:0]  stage_idx;
  logic [1:0]  group_idx;

  logic        d_start, d_abort, d_bf_ready;
  logic [63:0] d_N_in;
  logic        d_busy, d_issue_valid, d_r4_mode, d_done;
  logic [63:0] d_N_out;
  logic [1:0]  d_stage_idx;
  logic [9:0]  d_group_idx;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit busy;
    bit iv;
    bit dn;
    bit r4;
    bit chk_sg;
    int stg;
    int grp;
  } exp_t;

  typedef struct {
    logic [63:0] n;
    int lo_a;
    int lo_b;
    int abort_at;
    int sbusy_at;
    int exp_done;
    int exp_issues;
  } vec_t;

  exp_t exp_a [MAXC];
  bit   rdy   [MAXC];

  always #5 clk = ~clk;

  r16_ntt_stage_sched #(
    .P_WIDTH(64), .NUM_STAGE(NS), .GROUPS(GR), .PIPE_LAT(PL), .STG_W(1), .GRP_W(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .N_in(N_in),
    .bf_ready(bf_ready), .busy(busy), .N_out(N_out), .issue_valid(issue_valid),
    .stage_idx(stage_idx), .group_idx(group_idx), .r4_mode(r4_mode), .done(done)
  );

  r16_ntt_stage_sched u_dut_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort), .N_in(d_N_in),
    .bf_ready(d_bf_ready), .busy(d_busy), .N_out(d_N_out), .issue_valid(d_issue_valid),
    .stage_idx(d_stage_idx), .group_idx(d_group_idx), .r4_mode(d_r4_mode), .done(d_done)
  );

  function automatic exp_t mk(input bit b, input bit iv, input bit dn, input bit r4,
                              input bit chk, input int stg, input int grp);
    exp_t e;
    e.busy = b; e.iv = iv; e.dn = dn; e.r4 = r4; e.chk_sg = chk; e.stg = stg; e.grp = grp;
    return e;
  endfunction

  task automatic check(input string nm, input longint got, input longint want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  // Expected per-cycle schedule from the transform rules: cycle 0 carries
  // start, one LOAD cycle, then per stage one issue per ready cycle until all
  // groups are out, PL drain cycles, and finally one done cycle.
  task automatic build_model(input int abort_at, output int len, output int mdone);
    int c;
    int g;
    for (int i = 0; i < MAXC; i++) exp_a[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    exp_a[1] = mk(1'b1, 1'b0, 1'b0, NS == 1, 1'b1, 0, 0);
    c = 2;
    for (int s = 0; s < NS; s++) begin
      g = 0;
      while (g < GR) begin
        exp_a[c] = mk(1'b1, rdy[c], 1'b0, s == NS - 1, 1'b1, s, g);
        if (rdy[c]) g++;
        c++;
      end
      for (int d = 0; d < PL; d++) begin
        exp_a[c] = mk(1'b1, 1'b0, 1'b0, s == NS - 1, 1'b1, s, 0);
        c++;
      end
    end
    exp_a[c] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, NS - 1, 0);
    mdone = c;
    len   = c + 3;
    if (abort_at >= 0 && abort_at < mdone) begin
      for (int i = abort_at + 1; i < MAXC; i++) exp_a[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      mdone = -1;
      len   = abort_at + 4;
    end
  endtask

  // Drive one transform starting in cycle 0 and compare every cycle.
  // Entered and left just after a rising edge.
  task automatic run_vec(input int id, input logic [63:0] n, input int lo_a, input int lo_b,
                         input int abort_at, input int sbusy_at, input bit rnd,
                         output int done_cyc, output int issues, output int mdone);
    int len;
    bit ok;
    exp_t e;
    for (int c = 0; c < MAXC; c++)
      rdy[c] = rnd ? ((c >= 40) ? 1'b1 : ($urandom_range(0, 9) < 7)) : !(c >= lo_a && c <= lo_b);
    build_model(abort_at, len, mdone);
    done_cyc = -1;
    issues   = 0;
    for (int c = 0; c < len; c++) begin
      start    = (c == 0) || (c == sbusy_at);
      N_in     = (c == 0) ? n : ((c == sbusy_at) ? 64'd5 : {$urandom, $urandom});
      bf_ready = rdy[c];
      abort    = (c == abort_at);
      @(negedge clk);
      e = exp_a[c];
      if (issue_valid) issues++;
      if (done) done_cyc = c;
      ok = (busy == e.busy) && (issue_valid == e.iv) && (done == e.dn) && (r4_mode == e.r4)
           && (!e.chk_sg || (int'(stage_idx) == e.stg && int'(group_idx) == e.grp))
           && (c == 0 || N_out == n);
      n_assert++;
      if (!ok) begin
        n_fail++;
        $display("FAIL cycle_check vec%0d c%0d: got busy=%b iv=%b done=%b r4=%b stg=%0d grp=%0d N=%h want busy=%b iv=%b done=%b r4=%b stg=%0d grp=%0d N=%h",
                 id, c, busy, issue_valid, done, r4_mode, stage_idx, group_idx, N_out,
                 e.busy, e.iv, e.dn, e.r4, e.stg, e.grp, n);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    $display("vec %0d: N=%h issues=%0d done_cycle=%0d model_done=%0d", id, n, issues, done_cyc, mdone);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  busy,        0);
    check({tag, "_N_out"}, N_out,       0);
    check({tag, "_stage"}, stage_idx,   0);
    check({tag, "_group"}, group_idx,   0);
    check({tag, "_iv"},    issue_valid, 0);
    check({tag, "_r4"},    r4_mode,     0);
    check({tag, "_done"},  done,        0);
  endtask

  vec_t vt [5];

  initial begin
    int done_cyc, issues, mdone, ab;
    int d_cyc, d_issues, d_done_cyc, d_bad_grp, d_bad_r4;
    bit d_seen;
    int sq [$];

    vt[0] = '{64'hFFFF_FFFF_0000_0001, -1, -1, -1, -1, 16, 8};
    vt[1] = '{64'hFFFF_FFFF_0000_0001,  3,  4, -1, -1, 18, 8};
    vt[2] = '{64'hFFFF_FFFF_0000_0001, -1, -1, -1,  7, 16, 8};
    vt[3] = '{64'h0000_0000_7FFF_FFED, -1, -1, 10, -1, -1, 6};
    vt[4] = '{64'h0123_4567_89AB_CDEF, -1, -1, -1, -1, 16, 8};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bf_ready = 1'b1; N_in = '1;
    d_start = 1'b0; d_abort = 1'b0; d_bf_ready = 1'b1; d_N_in = '1;
    #12;
    check_reset("reset");
    check("reset_def_busy", d_busy, 0);
    check("reset_def_N", d_N_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: nominal, backpressure, start while busy, abort, restart
    for (int i = 0; i < 5; i++) begin
      run_vec(i, vt[i].n, vt[i].lo_a, vt[i].lo_b, vt[i].abort_at, vt[i].sbusy_at, 1'b0,
              done_cyc, issues, mdone);
      check($sformatf("done_cycle_v%0d", i), done_cyc, vt[i].exp_done);
      check($sformatf("issue_count_v%0d", i), issues, vt[i].exp_issues);
    end

    // Asynchronous reset in the middle of a transform
    start = 1'b1; N_in = 64'hAAAA_5555_AAAA_5555; bf_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(5, vt[0].n, -1, -1, -1, -1, 1'b0, done_cyc, issues, mdone);
    check("done_cycle_after_reset", done_cyc, 16);

    // Random handshake patterns against the schedule model
    for (int i = 0; i < 6; i++) begin
      ab = (i == 5) ? int'($urandom_range(3, 15)) : -1;
      run_vec(10 + i, {$urandom, $urandom}, -1, -1, ab, -1, 1'b1, done_cyc, issues, mdone);
      check($sformatf("rand_done_cycle_%0d", i), done_cyc, mdone);
      if (ab < 0) check($sformatf("rand_issue_count_%0d", i), issues, NS * GR);
    end

    // Default geometry: full-length transform
    d_start = 1'b1; d_N_in = 64'hFFFF_FFFF_0000_0001;
    @(posedge clk);
    #1;
    d_start = 1'b0;
    d_cyc = 1; d_issues = 0; d_done_cyc = -1; d_seen = 1'b0; d_bad_grp = 0; d_bad_r4 = 0;
    while (!d_seen && d_cyc < 5000) begin
      @(negedge clk);
      if (d_issue_valid) begin
        if (int'(d_group_idx) != d_issues % 1024) d_bad_grp++;
        if (d_r4_mode != (d_stage_idx == 2'd3)) d_bad_r4++;
        if (d_issues % 1024 == 0) sq.push_back(int'(d_stage_idx));
        d_issues++;
      end
      if (d_done) begin
        d_seen = 1'b1;
        d_done_cyc = d_cyc;
      end
      @(posedge clk);
      #1;
      d_cyc++;
    end
    if (!d_seen) $display("FAIL def_timeout: no done within 5000 cycles");
    check("def_done_cycle", d_done_cyc, 4114);
    check("def_issue_count", d_issues, 4096);
    check("def_group_seq_errors", d_bad_grp, 0);
    check("def_r4_errors", d_bad_r4, 0);
    check("def_stage_count", sq.size(), 4);
    for (int i = 0; i < sq.size() && i < 4; i++) check($sformatf("def_stage_seq_%0d", i), sq[i], i);
    check("def_N_out", d_N_out, 64'hFFFF_FFFF_0000_0001);
    $display("default run: issues=%0d done_cycle=%0d", d_issues, d_done_cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
